// File: rtl/ctrl_pipe_if.sv
// Handshake bundle between the decoder side and the control-word pipeline.
// The master drives the control inputs; the slave (the pipeline) drives the stage outputs.
interface ctrl_pipe_if #(
    parameter int CTRL_W = 10,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
);
    logic [CTRL_W-1:0]       ctrl_in;
    logic                    valid_in;
    logic [DEPTH-1:0]        stall_vec;
    logic [DEPTH-1:0]        flush_vec;
    logic                    clr_cnt;
    logic [DEPTH*CTRL_W-1:0] ctrl_stage;
    logic [DEPTH-1:0]        valid_stage;
    logic                    jump;
    logic                    reg_dest;
    logic                    alu_src;
    logic [1:0]              alu_op;
    logic [CNT_W-1:0]        bubble_cnt;

    modport master (
        output ctrl_in, valid_in, stall_vec, flush_vec, clr_cnt,
        input  ctrl_stage, valid_stage, jump, reg_dest, alu_src, alu_op, bubble_cnt
    );

    modport slave (
        input  ctrl_in, valid_in, stall_vec, flush_vec, clr_cnt,
        output ctrl_stage, valid_stage, jump, reg_dest, alu_src, alu_op, bubble_cnt
    );
endinterface

// File: rtl/ctrl_pipe_stages.sv
// DEPTH-stage pipeline for decoded control words with per-stage stall/flush,
// stage-0 field decode and a saturating count of bubbles leaving the last stage.
module ctrl_pipe_stages #(
    parameter int                CTRL_W     = 10,
    parameter int                DEPTH      = 3,
    parameter logic [CTRL_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 16
) (
    input logic        clk,
    input logic        reset,
    ctrl_pipe_if.slave bus
);

    logic [CTRL_W-1:0] ctrl_p [DEPTH];
    logic [DEPTH-1:0]  vld_p;
    logic [CTRL_W-1:0] src_ctrl [DEPTH];
    logic [DEPTH-1:0]  src_vld;
    logic [DEPTH-1:0]  hold;
    logic [DEPTH-1:0]  bub_in;
    logic [CNT_W-1:0]  cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A stall anywhere downstream freezes this stage too, so nothing is overwritten
    for (genvar g = 0; g < DEPTH; g++) begin : g_src
        assign hold[g] = |bus.stall_vec[DEPTH-1:g];
        if (g == 0) begin : g_head
            assign src_ctrl[g] = bus.ctrl_in;
            assign src_vld[g]  = bus.valid_in;
        end else begin : g_body
            assign src_ctrl[g] = ctrl_p[g-1];
            assign src_vld[g]  = vld_p[g-1];
        end
        assign bus.ctrl_stage[g*CTRL_W +: CTRL_W] = ctrl_p[g];
    end

    // Stage i receives a bubble whenever the stage feeding it is frozen
    assign bub_in = hold << 1;

    // Stage registers: flush > hold > upstream bubble > advance
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset || bus.flush_vec[i]) begin
                ctrl_p[i] <= BUBBLE_VAL;
                vld_p[i]  <= 1'b0;
            end else if (!hold[i]) begin
                if (bub_in[i]) begin
                    ctrl_p[i] <= BUBBLE_VAL;
                    vld_p[i]  <= 1'b0;
                end else begin
                    ctrl_p[i] <= src_ctrl[i];
                    vld_p[i]  <= src_vld[i];
                end
            end
        end
    end

    // Bubble profiling counter on the retiring stage
    always_ff @(posedge clk) begin
        if (reset || bus.clr_cnt) begin
            cnt_q <= '0;
        end else if (!vld_p[DEPTH-1]) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign bus.valid_stage = vld_p;
    assign bus.bubble_cnt  = cnt_q;
    assign bus.jump        = vld_p[0] & ctrl_p[0][9];
    assign bus.reg_dest    = vld_p[0] & ctrl_p[0][8];
    assign bus.alu_src     = vld_p[0] & ctrl_p[0][7];
    assign bus.alu_op      = vld_p[0] ? ctrl_p[0][1:0] : 2'b00;

endmodule

// File: tb/tb_ctrl_pipe_stages.sv
// Directed and randomized bench for ctrl_pipe_stages (DEPTH=3, CNT_W=4) against
// a cycle-level reference model built from the stall/flush/bubble rules.
module tb_ctrl_pipe_stages;
    localparam int CTRL_W  = 10;
    localparam int DEPTH   = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [CTRL_W-1:0] BUB = '0;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [CTRL_W-1:0] m_ctrl [DEPTH];
    logic              m_vld  [DEPTH];
    int                m_cnt;

    ctrl_pipe_if #(.CTRL_W(CTRL_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    ctrl_pipe_stages #(
        .CTRL_W(CTRL_W), .DEPTH(DEPTH), .BUBBLE_VAL(BUB), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [CTRL_W-1:0] c, input logic v,
                              input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl,
                              input logic cl, input logic rs);
        logic [CTRL_W-1:0] nc [DEPTH];
        logic              nv [DEPTH];
        if (rs) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_ctrl[i] = BUB;
                m_vld[i]  = 1'b0;
            end
            m_cnt = 0;
            return;
        end
        if (cl) m_cnt = 0;
        else if (!m_vld[DEPTH-1]) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        for (int i = 0; i < DEPTH; i++) begin
            if (fl[i]) begin
                nc[i] = BUB; nv[i] = 1'b0;
            end else if ((st >> i) != 0) begin
                nc[i] = m_ctrl[i]; nv[i] = m_vld[i];
            end else if (i > 0 && ((st >> (i - 1)) != 0)) begin
                nc[i] = BUB; nv[i] = 1'b0;
            end else if (i == 0) begin
                nc[i] = c; nv[i] = v;
            end else begin
                nc[i] = m_ctrl[i-1]; nv[i] = m_vld[i-1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            m_ctrl[i] = nc[i];
            m_vld[i]  = nv[i];
        end
    endtask

    task automatic check_all();
        logic [DEPTH*CTRL_W-1:0] ec;
        logic [DEPTH-1:0]        ev;
        logic [CTRL_W-1:0]       w0;
        for (int i = 0; i < DEPTH; i++) begin
            ec[i*CTRL_W +: CTRL_W] = m_ctrl[i];
            ev[i] = m_vld[i];
        end
        w0 = m_ctrl[0];
        chk("ctrl_stage", bus.ctrl_stage, ec);
        chk("valid_stage", bus.valid_stage, ev);
        chk("jump", bus.jump, m_vld[0] & w0[9]);
        chk("reg_dest", bus.reg_dest, m_vld[0] & w0[8]);
        chk("alu_src", bus.alu_src, m_vld[0] & w0[7]);
        chk("alu_op", bus.alu_op, m_vld[0] ? w0[1:0] : 2'b00);
        chk("bubble_cnt", bus.bubble_cnt, m_cnt[CNT_W-1:0]);
    endtask

    task automatic step(input logic [CTRL_W-1:0] c, input logic v,
                        input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl,
                        input logic cl, input logic rs);
        bus.ctrl_in   = c;
        bus.valid_in  = v;
        bus.stall_vec = st;
        bus.flush_vec = fl;
        bus.clr_cnt   = cl;
        reset         = rs;
        @(posedge clk);
        model_step(c, v, st, fl, cl, rs);
        #1;
        check_all();
    endtask

    task automatic idle();
        step('0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic feed(input logic [CTRL_W-1:0] c, input logic [DEPTH-1:0] st,
                        input logic [DEPTH-1:0] fl);
        step(c, 1'b1, st, fl, 1'b0, 1'b0);
    endtask

    initial begin
        bus.ctrl_in = '0; bus.valid_in = 1'b0; bus.stall_vec = '0;
        bus.flush_vec = '0; bus.clr_cnt = 1'b0; reset = 1'b1;

        // initial reset
        step('0, 1'b0, '0, '0, 1'b0, 1'b1);
        step(10'h3FF, 1'b1, '0, '0, 1'b0, 1'b1);
        chk("rst_valid", bus.valid_stage, 3'b000);
        chk("rst_ctrl", bus.ctrl_stage, 30'h0);
        chk("rst_cnt", bus.bubble_cnt, 4'h0);
        chk("rst_alu_op", bus.alu_op, 2'b00);

        // T2 flow
        feed(10'h3A1, '0, '0);
        chk("t2_s0", bus.ctrl_stage[9:0], 10'h3A1);
        chk("t2_jump", bus.jump, 1'b1);
        chk("t2_reg_dest", bus.reg_dest, 1'b1);
        chk("t2_alu_src", bus.alu_src, 1'b1);
        chk("t2_alu_op", bus.alu_op, 2'b01);
        feed(10'h0C2, '0, '0);
        feed(10'h205, '0, '0);
        chk("t2_s2_c3", bus.ctrl_stage[29:20], 10'h3A1);
        chk("t2_v2_c3", bus.valid_stage[2], 1'b1);
        idle();
        chk("t2_s2_c4", bus.ctrl_stage[29:20], 10'h0C2);
        idle();
        chk("t2_s2_c5", bus.ctrl_stage[29:20], 10'h205);
        idle(); idle(); idle();

        // T3 stall at stage 0
        feed(10'h3A1, '0, '0);
        step(10'h0C2, 1'b1, '0, '0, 1'b1, 1'b0);
        chk("t3_cnt_clr", bus.bubble_cnt, 4'h0);
        feed(10'h205, 3'b001, '0);
        chk("t3_s0_hold1", bus.ctrl_stage[9:0], 10'h0C2);
        chk("t3_v1_bub1", bus.valid_stage[1], 1'b0);
        feed(10'h205, 3'b001, '0);
        chk("t3_s0_hold2", bus.ctrl_stage[9:0], 10'h0C2);
        chk("t3_v1_bub2", bus.valid_stage[1], 1'b0);
        feed(10'h205, '0, '0);
        chk("t3_s1", bus.ctrl_stage[19:10], 10'h0C2);
        idle(); idle(); idle();
        chk("t3_cnt", bus.bubble_cnt, 4'h3);

        // T4 stall at stage 1 only
        feed(10'h111, '0, '0);
        feed(10'h222, '0, '0);
        feed(10'h333, '0, '0);
        feed(10'h044, 3'b010, '0);
        chk("t4_s0", bus.ctrl_stage[9:0], 10'h333);
        chk("t4_s1", bus.ctrl_stage[19:10], 10'h222);
        chk("t4_v2", bus.valid_stage[2], 1'b0);
        feed(10'h044, '0, '0);
        chk("t4_s2_a", bus.ctrl_stage[29:20], 10'h222);
        idle();
        chk("t4_s2_b", bus.ctrl_stage[29:20], 10'h333);
        idle();
        chk("t4_s2_c", bus.ctrl_stage[29:20], 10'h044);

        // T5 flush and stall together on stage 0
        feed(10'h3A1, '0, '0);
        feed(10'h0C2, 3'b001, 3'b001);
        chk("t5_v0", bus.valid_stage[0], 1'b0);
        chk("t5_s0", bus.ctrl_stage[9:0], 10'h000);
        chk("t5_jump", bus.jump, 1'b0);
        chk("t5_reg_dest", bus.reg_dest, 1'b0);
        chk("t5_alu_op", bus.alu_op, 2'b00);

        // T6 counter saturation and clear
        step('0, 1'b0, '0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) idle();
        chk("t6_sat", bus.bubble_cnt, 4'hF);
        idle();
        chk("t6_sat_hold", bus.bubble_cnt, 4'hF);
        step('0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("t6_clr", bus.bubble_cnt, 4'h0);
        idle();
        chk("t6_resume", bus.bubble_cnt, 4'h1);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            logic [DEPTH-1:0] st, fl;
            st = ($urandom_range(3) == 0) ? DEPTH'($urandom) : '0;
            fl = ($urandom_range(7) == 0) ? DEPTH'($urandom) : '0;
            step(CTRL_W'($urandom), 1'($urandom), st, fl,
                 $urandom_range(29) == 0, $urandom_range(59) == 0);
        end

        // T1 reset mid-stream
        feed(10'h3A1, '0, '0);
        feed(10'h0C2, '0, '0);
        step(10'h205, 1'b1, '0, '0, 1'b0, 1'b1);
        step(10'h205, 1'b1, 3'b001, '0, 1'b0, 1'b1);
        chk("t1_valid", bus.valid_stage, 3'b000);
        chk("t1_ctrl", bus.ctrl_stage, 30'h0);
        chk("t1_cnt", bus.bubble_cnt, 4'h0);
        chk("t1_alu_op", bus.alu_op, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
